spm_seq: RTL
============

SPM_SEQ -- requirements
Module: spm_seq

Interface
REQ-001 Parameter XW, default 32: multiplicand (X) width in bits, legal range 2..64.
REQ-002 Parameter YW, default 32: multiplier (Y) width in bits, legal range 2..64.
REQ-003 Parameter SIGNED, default 0: 0 = unsigned operands, 1 = two's-complement operands.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by external logic.
REQ-006 START  input  1  request; sampled only when BUSY=0.
REQ-007 X  input  XW  parallel multiplicand, captured on accepted START.
REQ-008 Y  input  YW  multiplier, captured on accepted START, consumed serially LSB-first.
REQ-009 BUSY  output  1  high while a product is being computed.
REQ-010 P_SER  output  1  current serial product bit, LSB-first.
REQ-011 P_VLD  output  1  qualifies P_SER; high exactly during the XW+YW product-bit cycles.
REQ-012 DONE  output  1  one-cycle pulse after the last product bit.
REQ-013 P  output  XW+YW  parallel product, held stable from DONE until the next accepted START.

Function
REQ-014 FSM states: IDLE, RUN, FIN; encoding free.
REQ-015 IDLE: BUSY=0; START=1 at a rising edge captures X, Y, clears the carry-save array and bit counter, moves to RUN.
REQ-016 RUN: BUSY=1; lasts exactly XW+YW cycles, counted by an internal counter of clog2(XW+YW+1) bits.
REQ-017 RUN cycle k (k=0..XW+YW-1): serial multiplier bit = Y[k] for k<YW; for k>=YW it is Y[YW-1] if SIGNED=1, else 0.
REQ-018 Core: carry-save serial/parallel array of XW cells; each cell adds (X[i] AND y_bit) + incoming partial sum + own carry and shifts toward LSB; when SIGNED=1 the MSB cell applies two's-complement sign correction so the result is the signed product.
REQ-019 RUN cycle k: P_SER = product bit k, P_VLD=1, and the bit is shifted into P from the MSB end, so P holds the full product after the last RUN cycle.
REQ-020 Result: P = (X*Y) mod 2^(XW+YW), with operands interpreted per SIGNED; no overflow is possible.
REQ-021 Latency: accepted START at edge t -> first P_VLD cycle begins at t; last product bit in cycle t+XW+YW-1; DONE high in cycle t+XW+YW (FIN).
REQ-022 FIN: one cycle, DONE=1, BUSY=0, P_VLD=0, P final; then IDLE unconditionally.
REQ-023 START in FIN is accepted exactly as in IDLE (back-to-back operation, one-cycle gap between product streams).
REQ-024 START while BUSY=1 is ignored; X, Y changes during RUN do not affect the result.
REQ-025 P, P_SER hold value outside RUN; P_SER is don't-care when P_VLD=0 but shall not toggle.
REQ-026 Operands 0 or all-ones, and SIGNED=1 most-negative x most-negative, shall produce the exact product.

Reset
REQ-027 RST=0 immediately forces IDLE, BUSY=0, P_VLD=0, DONE=0, P_SER=0, P=0, counter and array cleared, regardless of clock.
REQ-028 Reset during RUN abandons the operation; no DONE pulse is produced for it.
REQ-029 First START accepted is at the first rising edge with RST=1 and START=1.

Verification
REQ-030 XW=YW=8, SIGNED=0: X=4, Y=1, START one cycle -> P_VLD 16 cycles, P_SER stream 0,0,1,0...0, DONE next cycle, P=16'h0004.
REQ-031 XW=YW=8, SIGNED=0: X=255, Y=255 -> P=16'hFE01 (65025); then START in FIN cycle with X=3, Y=1 -> P=16'h0003 after 16 more cycles.
REQ-032 XW=YW=8, SIGNED=1: X=-3 (8'hFD), Y=5 -> P=16'hFFF1; X=8'h80, Y=8'h80 -> P=16'h4000.
REQ-033 START pulses and X/Y changes during RUN -> ignored; result matches values captured at accept, BUSY stays high exactly 16 cycles.
REQ-034 RST=0 asserted mid-RUN between clock edges -> all outputs zero immediately, no DONE; next START computes correctly.
REQ-035 Default XW=YW=32, random operands both modes -> P matches reference model, DONE exactly 64 cycles after accept.

Source files
------------

// File: rtl/spm_seq.sv
// -----------------------------------------------------------------------------
// spm_seq -- sequential serial/parallel multiplier (carry-save array).
//
// The multiplicand X is held in parallel. The multiplier Y is consumed one bit
// per cycle, LSB first. Each RUN cycle produces one product bit, LSB first, on
// P_SER. The same bit is shifted into P from the MSB end, so P holds the whole
// product once the stream ends.
//
// Parameters
//   XW      multiplicand width (2..64)
//   YW      multiplier width   (2..64)
//   SIGNED  0 = unsigned operands, 1 = two's-complement operands
//
// Ports
//   CLK     clock, rising edge
//   RST     asynchronous active-low reset
//   START   request, sampled when BUSY=0 (IDLE or FIN)
//   X, Y    operands, captured on an accepted START
//   BUSY    high during the XW+YW RUN cycles
//   P_SER   current product bit; holds its value outside RUN
//   P_VLD   qualifies P_SER (high exactly during RUN)
//   DONE    one-cycle pulse (FIN) after the last product bit
//   P       parallel product, stable from DONE until the next accepted START
// -----------------------------------------------------------------------------
module spm_seq #(
    parameter int XW     = 32,
    parameter int YW     = 32,
    parameter int SIGNED = 0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [XW-1:0]      X,
    input  logic [YW-1:0]      Y,
    output logic               BUSY,
    output logic               P_SER,
    output logic               P_VLD,
    output logic               DONE,
    output logic [XW+YW-1:0]   P
);

    localparam int              PW       = XW + YW;
    localparam int              CW       = $clog2(PW + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(PW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [XW-1:0]   x_reg;
    logic [YW-1:0]   y_reg;
    // s_reg[i] is the partial sum travelling into cell i (from cell i+1).
    // The MSB cell has no upper neighbour, so it needs no register.
    logic [XW-2:0]   s_reg;
    logic [XW-1:0]   c_reg;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   p_reg;
    logic            p_ser_reg;

    logic            accept;
    logic            y_bit;
    logic            y_fill;
    logic            first_cycle;
    logic [XW-1:0]   cell_s;
    logic [XW-1:0]   cell_c;

    assign accept      = START && ((state_reg == IDLE) || (state_reg == FIN));
    assign y_bit       = y_reg[0];
    // Once Y has been shifted out, the multiplier is sign-extended.
    // In unsigned mode it is zero-extended instead.
    assign y_fill      = (SIGNED != 0) ? y_reg[YW-1] : 1'b0;
    assign first_cycle = (cnt_reg == '0);

    // ---------------------------------------------------------------------
    // Carry-save array. Cell i adds three terms:
    //   - its partial-product bit,
    //   - the partial sum coming in from cell i+1,
    //   - its own carry.
    // The carry stays in the cell. The sum moves one place toward the LSB,
    // which makes the accumulator shift right one bit per cycle. Cell 0's
    // sum is the finished product bit for the cycle.
    //
    // Signed correction: X's MSB has negative weight. The MSB cell handles
    // this by inverting its partial-product bit (-z == ~z - 1). Over
    // XW+YW rows, the -1 terms add up to +2^(XW-1) modulo 2^(XW+YW).
    // That constant enters the MSB cell as an incoming sum of 1 in cycle 0.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < XW; gi++) begin : g_cell
            logic       pp;
            logic       sin;
            logic [1:0] tot;

            if (gi == XW - 1) begin : g_msb
                if (SIGNED != 0) begin : g_sgn
                    assign pp  = ~(x_reg[gi] & y_bit);
                    assign sin = first_cycle;
                end else begin : g_uns
                    assign pp  = x_reg[gi] & y_bit;
                    assign sin = 1'b0;
                end
            end else begin : g_mid
                assign pp  = x_reg[gi] & y_bit;
                assign sin = s_reg[gi];
            end

            assign tot        = {1'b0, pp} + {1'b0, sin} + {1'b0, c_reg[gi]};
            assign cell_s[gi] = tot[0];
            assign cell_c[gi] = tot[1];
        end
    endgenerate

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and outputs
    always_comb begin
        state_next = state_reg;
        BUSY       = 1'b0;
        P_VLD      = 1'b0;
        DONE       = 1'b0;
        P_SER      = p_ser_reg;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                BUSY  = 1'b1;
                P_VLD = 1'b1;
                P_SER = cell_s[0];
                if (cnt_reg == LAST_CNT) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                DONE       = 1'b1;
                state_next = START ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            x_reg     <= '0;
            y_reg     <= '0;
            s_reg     <= '0;
            c_reg     <= '0;
            cnt_reg   <= '0;
            p_reg     <= '0;
            p_ser_reg <= 1'b0;
        end else if (accept) begin
            x_reg   <= X;
            y_reg   <= Y;
            s_reg   <= '0;
            c_reg   <= '0;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            y_reg     <= {y_fill, y_reg[YW-1:1]};
            s_reg     <= cell_s[XW-1:1];
            c_reg     <= cell_c;
            cnt_reg   <= cnt_reg + CW'(1);
            p_reg     <= {cell_s[0], p_reg[PW-1:1]};
            p_ser_reg <= cell_s[0];
        end
    end

    assign P = p_reg;

endmodule
